// File: rtl/store_issue_if.sv
// Data-side SRAM-like bus between the store issuer (master) and the memory interface (slave).
interface store_issue_if #(
    parameter int AW = 32
) ();
    logic          data_sram_req;
    logic          data_sram_wr;
    logic [1:0]    data_sram_size;
    logic [AW-1:0] data_sram_addr;
    logic [3:0]    data_sram_wstrb;
    logic [31:0]   data_sram_wdata;
    logic          data_sram_addr_ok;
    logic          data_sram_data_ok;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
               data_sram_wstrb, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
               data_sram_wstrb, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok
    );
endinterface

// File: rtl/store_issue.sv
// Memory-stage store issuer: lane-aligns stores, buffers them and issues one at a time on the data bus.
// Define ST_ALE_CHECK_EN to reject misaligned stores with an st_ale pulse instead of force-aligning them.
module store_issue #(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [AW-1:0]          st_addr,
    input  logic [1:0]             st_sz,
    input  logic [31:0]            st_data,
    output logic                   st_ale,
    store_issue_if.master          bus,
    output logic                   sb_empty,
    output logic [$clog2(DEPTH):0] sb_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [AW-1:0] addr_mem  [DEPTH];
    logic [1:0]    size_mem  [DEPTH];
    logic [3:0]    wstrb_mem [DEPTH];
    logic [31:0]   wdata_mem [DEPTH];

    logic          accept_ok;
    logic          push, pop;
    logic [AW-1:0] eff_addr;
    logic [3:0]    ent_wstrb;
    logic [31:0]   ent_wdata;

`ifdef ST_ALE_CHECK_EN
    logic misaligned;
    assign misaligned = (st_sz == 2'd1) ? st_addr[0] : (st_sz[1] ? |st_addr[1:0] : 1'b0);
    assign st_ale     = st_valid & misaligned;
    assign accept_ok  = ~misaligned;
`else
    assign st_ale    = 1'b0;
    assign accept_ok = 1'b1;
`endif

    // Size 3 falls into the word lane; the cleared address only matters when alignment is forced.
    always_comb begin
        eff_addr  = st_addr;
        ent_wstrb = 4'b1111;
        ent_wdata = st_data;
        case (st_sz)
            2'd0: begin
                ent_wstrb = 4'b0001 << eff_addr[1:0];
                ent_wdata = {4{st_data[7:0]}};
            end
            2'd1: begin
                eff_addr[0] = 1'b0;
                ent_wstrb   = 4'b0011 << eff_addr[1:0];
                ent_wdata   = {2{st_data[15:0]}};
            end
            default: eff_addr[1:0] = 2'b00;
        endcase
    end

    always_comb begin
        pop      = (state_q == WAIT) & bus.data_sram_data_ok;
        st_ready = (count_q < DEPTH_C) | pop;
        push     = st_valid & st_ready & accept_ok;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (count_d != '0) state_d = REQ;
            REQ:     if (bus.data_sram_addr_ok) state_d = WAIT;
            WAIT:    if (pop) state_d = (count_d != '0) ? REQ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q]  <= eff_addr;
            size_mem[wr_ptr_q]  <= st_sz;
            wstrb_mem[wr_ptr_q] <= ent_wstrb;
            wdata_mem[wr_ptr_q] <= ent_wdata;
        end
    end

    // Head fields are gated so the bus reads zero whenever no request is presented.
    always_comb begin
        bus.data_sram_req   = (state_q == REQ);
        bus.data_sram_wr    = bus.data_sram_req;
        bus.data_sram_size  = bus.data_sram_req ? size_mem[rd_ptr_q]  : '0;
        bus.data_sram_addr  = bus.data_sram_req ? addr_mem[rd_ptr_q]  : '0;
        bus.data_sram_wstrb = bus.data_sram_req ? wstrb_mem[rd_ptr_q] : '0;
        bus.data_sram_wdata = bus.data_sram_req ? wdata_mem[rd_ptr_q] : '0;
        sb_empty            = (count_q == '0) & (state_q == IDLE);
        sb_count            = count_q;
    end
endmodule
